// File: rtl/addecrc_pad.sv
// rtl/addecrc_pad.sv - frame pass-through with minimum-length padding and reflected CRC append
// Output trails input by one cycle; pad and CRC tail bytes follow the last data byte gaplessly.
module addecrc_pad #(
  parameter int              CW      = 32,
  parameter logic [CW-1:0]   TAPS    = CW'(32'hedb88320),
  parameter bit              INVERT  = 1'b1,
  parameter int              MINLEN  = 60,
  parameter logic [7:0]      PADBYTE = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_pad,
  input  logic       i_v,
  input  logic [7:0] i_d,
  output logic       o_v,
  output logic [7:0] o_d,
  output logic       o_busy,
  output logic       o_drop
);

  localparam int NB = CW / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int KW = (MINLEN > 0) ? $clog2(MINLEN + 1) : 1;
  localparam logic [KW-1:0] MIN_K  = KW'(MINLEN);
  localparam logic [IW-1:0] LAST_I = IW'(NB - 1);
  localparam logic [CW-1:0] PRESET = INVERT ? {CW{1'b1}} : {CW{1'b0}};
  localparam logic [7:0]    XMASK  = INVERT ? 8'hff : 8'h00;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_CRC  = 2'd3;

  function automatic logic [CW-1:0] tab_entry(input logic [7:0] idx);
    logic [CW-1:0] c;
    c = CW'(idx);
    for (int k = 0; k < 8; k++)
      c = c[0] ? ((c >> 1) ^ TAPS) : (c >> 1);
    return c;
  endfunction

  logic [CW-1:0] crc_tab [256];
  for (genvar g = 0; g < 256; g++) begin : g_tab
    assign crc_tab[g] = tab_entry(8'(g));
  end

  logic [1:0]    state;
  logic          en_r;
  logic          pad_r;
  logic          discard;
  logic [CW-1:0] crc;
  logic [KW-1:0] count;
  logic [IW-1:0] idx;

  logic          start;
  logic          below_min;
  logic          data_cycle;
  logic [CW-1:0] crc_base;
  logic [7:0]    upd_byte;
  logic [CW-1:0] crc_upd;

  generate
    if (MINLEN > 0) begin : g_min
      assign below_min = (count < MIN_K);
    end else begin : g_nomin
      assign below_min = 1'b0;
    end
  endgenerate

  // A burst that collided with a tail stays discarded until i_v drops.
  always_comb begin
    start      = i_v && !o_busy && !discard;
    data_cycle = (state == S_IDLE) || ((state == S_DATA) && i_v);
    crc_base   = (state == S_IDLE) ? PRESET : crc;
    upd_byte   = data_cycle ? i_d : PADBYTE;
    crc_upd    = (crc_base >> 8) ^ crc_tab[crc_base[7:0] ^ upd_byte];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= S_IDLE;
      en_r    <= 1'b0;
      pad_r   <= 1'b0;
      discard <= 1'b0;
      crc     <= PRESET;
      count   <= '0;
      idx     <= '0;
      o_v     <= 1'b0;
      o_d     <= 8'h00;
      o_busy  <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      o_drop  <= i_v && o_busy;
      discard <= i_v && (o_busy || discard);
      case (state)
        S_IDLE: begin
          o_busy <= 1'b0;
          o_v    <= start;
          if (start) begin
            en_r  <= i_en;
            pad_r <= i_pad;
            o_d   <= i_d;
            crc   <= crc_upd;
            count <= KW'(1);
            state <= S_DATA;
          end
        end
        S_DATA, S_PAD: begin
          if ((state == S_DATA) && i_v) begin
            o_v <= 1'b1;
            o_d <= i_d;
            crc <= crc_upd;
            if (below_min) count <= count + 1'b1;
          end else if (pad_r && below_min) begin
            o_v    <= 1'b1;
            o_busy <= 1'b1;
            o_d    <= PADBYTE;
            crc    <= crc_upd;
            count  <= count + 1'b1;
            state  <= S_PAD;
          end else if (en_r) begin
            o_v    <= 1'b1;
            o_busy <= 1'b1;
            o_d    <= crc[7:0] ^ XMASK;
            crc    <= crc >> 8;
            idx    <= IW'(1);
            state  <= S_CRC;
          end else begin
            o_v    <= 1'b0;
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          o_v    <= 1'b1;
          o_busy <= 1'b1;
          o_d    <= crc[7:0] ^ XMASK;
          crc    <= crc >> 8;
          idx    <= idx + 1'b1;
          if (idx == LAST_I) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addecrc_pad.sv
// tb/tb_addecrc_pad.sv - table, directed and randomized checks of addecrc_pad
// Expected streams come from a frame-level model with a bit-serial CRC.
module tb_addecrc_pad;
  localparam int MINLEN = 60;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int         n;
    logic [7:0] base;
    logic       ee;
    logic       pp;
    int         exp_len;
    int         exp_busy;
    bit         has_crc;
    logic [31:0] exp_crc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, pad, v;
  logic [7:0] d;
  logic       ov, busy, drop, ov16, busy16, drop16;
  logic [7:0] od, od16;

  addecrc_pad dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_pad(pad), .i_v(v), .i_d(d),
    .o_v(ov), .o_d(od), .o_busy(busy), .o_drop(drop)
  );

  addecrc_pad #(.CW(16), .TAPS(16'h8408), .INVERT(1'b1), .MINLEN(0)) dut16 (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(1'b1), .i_pad(1'b0), .i_v(v), .i_d(d),
    .o_v(ov16), .o_d(od16), .o_busy(busy16), .o_drop(drop16)
  );

  int checks = 0;
  int failures = 0;

  logic       s_v[$], s_en[$], s_pad[$];
  logic [7:0] s_d[$];
  logic [10:0] log32[$];
  bq_t        bytes32, bytes16;
  int         ov_first, ov_last, ov_cnt, busy_cnt, drop_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sw_crc(input bq_t b, input int cw, input logic [31:0] taps);
    logic [31:0] c, mask;
    mask = (cw == 32) ? 32'hffff_ffff : 32'h0000_ffff;
    c = mask;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        logic fb;
        fb = c[0] ^ b[i][k];
        c = c >> 1;
        if (fb) c = c ^ taps;
      end
    end
    return c ^ mask;
  endfunction

  function automatic bq_t frame_out(input bq_t data, input logic ee, input logic pp);
    bq_t out;
    logic [31:0] c;
    out = data;
    if (pp) while (out.size() < MINLEN) out.push_back(8'h00);
    if (ee) begin
      c = sw_crc(out, 32, 32'hedb88320);
      for (int k = 0; k < 4; k++) out.push_back(c[8*k +: 8]);
    end
    return out;
  endfunction

  function automatic logic [31:0] get32(input bq_t q, input int i);
    if (i < 0 || i + 3 >= q.size()) return 32'h0;
    return {q[i+3], q[i+2], q[i+1], q[i]};
  endfunction

  task automatic clear_stim();
    s_v = {}; s_d = {}; s_en = {}; s_pad = {};
  endtask

  task automatic push_cycle(input logic vv, input logic [7:0] dd, input logic ee, input logic pp);
    s_v.push_back(vv); s_d.push_back(dd); s_en.push_back(ee); s_pad.push_back(pp);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Mode inputs flip after the first byte; the DUT must ignore that.
  task automatic push_frame(input int n, input logic [7:0] base, input logic ee, input logic pp);
    for (int i = 0; i < n; i++)
      push_cycle(1'b1, base + 8'(i), (i == 0) ? ee : ~ee, (i == 0) ? pp : ~pp);
  endtask

  task automatic run_stim();
    log32 = {}; bytes32 = {}; bytes16 = {};
    ov_first = -1; ov_last = -1; ov_cnt = 0; busy_cnt = 0; drop_cnt = 0;
    for (int c = 0; c < s_v.size(); c++) begin
      v = s_v[c]; d = s_d[c]; en = s_en[c]; pad = s_pad[c];
      @(negedge clk);
      log32.push_back({ov, ov ? od : 8'h00, busy, drop});
      if (ov) begin
        bytes32.push_back(od);
        ov_cnt++;
        if (ov_first < 0) ov_first = c;
        ov_last = c;
      end
      busy_cnt += int'(busy);
      drop_cnt += int'(drop);
      if (ov16) bytes16.push_back(od16);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_check(input string name);
    int n;
    int busy_end;
    int c;
    int bad;
    int first_bad;
    bit disc;
    logic [10:0] expv[];
    n = s_v.size();
    busy_end = -1; c = 0; bad = 0; first_bad = -1; disc = 1'b0;
    expv = new[n + 80];
    foreach (expv[i]) expv[i] = 11'h0;
    while (c < n) begin
      if (!s_v[c]) begin
        disc = 1'b0;
        c++;
      end else if (c <= busy_end || disc) begin
        if (c <= busy_end) expv[c+1][0] = 1'b1;
        disc = 1'b1;
        c++;
      end else begin
        int t;
        logic ee, pp;
        bq_t data, out;
        t = c; ee = s_en[c]; pp = s_pad[c];
        while (c < n && s_v[c]) begin
          data.push_back(s_d[c]);
          c++;
        end
        out = frame_out(data, ee, pp);
        foreach (out[k]) begin
          expv[t+1+k][10]  = 1'b1;
          expv[t+1+k][9:2] = out[k];
          if (k >= data.size()) expv[t+1+k][1] = 1'b1;
        end
        busy_end = t + out.size();
      end
    end
    for (int i = 0; i < n; i++) begin
      if (log32[i] !== expv[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (bad > 0)
      $display("  %s first diff at cycle %0d: got %h want %h", name, first_bad, log32[first_bad], expv[first_bad]);
    check({name, " stream diffs"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    tbl[0] = '{9,  8'h31, 1'b1, 1'b0, 13, 4,  1'b1, 32'hcbf43926};
    tbl[1] = '{1,  8'haa, 1'b1, 1'b1, 64, 63, 1'b0, 32'h0};
    tbl[2] = '{5,  8'h10, 1'b0, 1'b0, 5,  0,  1'b0, 32'h0};
    tbl[3] = '{1,  8'haa, 1'b0, 1'b1, 60, 59, 1'b0, 32'h0};
    tbl[4] = '{9,  8'h31, 1'b1, 1'b1, 64, 55, 1'b0, 32'h0};
    tbl[5] = '{61, 8'h00, 1'b1, 1'b1, 65, 4,  1'b0, 32'h0};
    tbl[6] = '{60, 8'h40, 1'b0, 1'b1, 60, 0,  1'b0, 32'h0};

    rst_n = 1'b0; v = 1'b0; d = 8'h00; en = 1'b0; pad = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset o_v", ov, 0);
    check("reset o_d", od, 0);
    check("reset o_busy", busy, 0);
    check("reset o_drop", drop, 0);
    check("reset crc16 o_v", ov16, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      clear_stim();
      push_idle(2);
      push_frame(tbl[i].n, tbl[i].base, tbl[i].ee, tbl[i].pp);
      push_idle(80);
      run_stim();
      model_check(nm);
      check({nm, " o_v count"}, ov_cnt, tbl[i].exp_len);
      check({nm, " o_v span"}, ov_last - ov_first + 1, tbl[i].exp_len);
      check({nm, " latency"}, ov_first, 3);
      check({nm, " busy cycles"}, busy_cnt, tbl[i].exp_busy);
      check({nm, " drops"}, drop_cnt, 0);
      if (tbl[i].has_crc) check({nm, " crc bytes"}, get32(bytes32, bytes32.size() - 4), tbl[i].exp_crc);
    end

    // Back-to-back frames without tail, one idle cycle apart
    clear_stim();
    push_idle(2);
    push_frame(5, 8'h10, 1'b0, 1'b0);
    push_idle(1);
    push_frame(5, 8'h50, 1'b0, 1'b0);
    push_idle(20);
    run_stim();
    model_check("b2b");
    check("b2b o_v count", ov_cnt, 10);
    check("b2b o_v span", ov_last - ov_first + 1, 11);
    check("b2b busy", busy_cnt, 0);
    check("b2b drops", drop_cnt, 0);

    // Two-byte burst during the CRC tail, then a legal frame
    clear_stim();
    push_idle(2);
    push_frame(9, 8'h31, 1'b1, 1'b0);
    push_idle(2);
    push_frame(2, 8'hee, 1'b0, 1'b0);
    push_idle(3);
    push_frame(9, 8'h31, 1'b1, 1'b0);
    push_idle(80);
    run_stim();
    model_check("drop");
    check("drop pulses", drop_cnt, 2);
    check("drop o_v count", ov_cnt, 26);
    check("drop first crc", get32(bytes32, 9), 32'hcbf43926);
    check("drop second crc", get32(bytes32, 22), 32'hcbf43926);

    // Reset asserted while the second CRC byte is on the output
    clear_stim();
    push_idle(2);
    push_frame(9, 8'h31, 1'b1, 1'b0);
    push_idle(2);
    run_stim();
    check("rst pre o_v", ov, 1);
    check("rst pre byte", od, 8'h39);
    rst_n = 1'b0;
    #1;
    check("rst async o_v", ov, 0);
    check("rst async o_busy", busy, 0);
    check("rst async o_drop", drop, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stim();
    push_idle(8);
    run_stim();
    check("rst quiet o_v", ov_cnt, 0);
    clear_stim();
    push_idle(2);
    push_frame(9, 8'h31, 1'b1, 1'b0);
    push_idle(20);
    run_stim();
    model_check("rst after");
    check("rst after crc", get32(bytes32, 9), 32'hcbf43926);

    // CRC-16/X-25 instance
    clear_stim();
    push_idle(2);
    push_frame(9, 8'h31, 1'b1, 1'b0);
    push_idle(20);
    run_stim();
    check("crc16 o_v count", bytes16.size(), 11);
    check("crc16 bytes", (bytes16.size() == 11) ? {16'h0, bytes16[10], bytes16[9]} : 32'h0, 32'h906e);

    for (int r = 0; r < 3; r++) begin
      clear_stim();
      push_idle(3);
      for (int f = 0; f < 40; f++) begin
        int n;
        logic ee, pp;
        n = $urandom_range(1, 70);
        ee = 1'($urandom);
        pp = 1'($urandom);
        for (int i = 0; i < n; i++)
          push_cycle(1'b1, 8'($urandom), (i == 0) ? ee : 1'($urandom), (i == 0) ? pp : 1'($urandom));
        push_idle($urandom_range(1, 8));
      end
      push_idle(80);
      run_stim();
      model_check($sformatf("random%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
